// File: rtl/y86_execute.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | y86_execute: Y86-64 SEQ execute stage (ALU, condition codes, cnd)          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module y86_execute #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         alu_err
);

  localparam logic [3:0] c_CMOV  = 4'h2;
  localparam logic [3:0] c_IRMOV = 4'h3;
  localparam logic [3:0] c_RMMOV = 4'h4;
  localparam logic [3:0] c_MRMOV = 4'h5;
  localparam logic [3:0] c_OPQ   = 4'h6;
  localparam logic [3:0] c_JXX   = 4'h7;
  localparam logic [3:0] c_CALL  = 4'h8;
  localparam logic [3:0] c_RET   = 4'h9;
  localparam logic [3:0] c_PUSH  = 4'hA;
  localparam logic [3:0] c_POP   = 4'hB;

  localparam logic [3:0] c_ADD = 4'h0;
  localparam logic [3:0] c_SUB = 4'h1;
  localparam logic [3:0] c_AND = 4'h2;
  localparam logic [3:0] c_XOR = 4'h3;

  localparam logic [W-1:0] c_EIGHT = W'(8);

  logic r_zf;
  logic r_sf;
  logic r_of;
  logic w_of;
  logic w_cc_we;
  logic w_lt;

  always_comb begin
    valE    = '0;
    alu_err = 1'b0;
    case (icode)
      c_CMOV:          valE = valA;
      c_IRMOV:         valE = valC;
      c_RMMOV, c_MRMOV: valE = valB + valC;
      c_OPQ: begin
        case (ifun)
          c_ADD:   valE = valB + valA;
          c_SUB:   valE = valB - valA;
          c_AND:   valE = valB & valA;
          c_XOR:   valE = valB ^ valA;
          default: alu_err = 1'b1;
        endcase
      end
      c_CALL, c_PUSH:  valE = valB - c_EIGHT;
      c_RET, c_POP:    valE = valB + c_EIGHT;
      default:         valE = '0;
    endcase
  end

  // Signed overflow from operand/result sign bits; logical ops never overflow.
  always_comb begin
    w_of = 1'b0;
    case (ifun)
      c_ADD:   w_of = (valA[W-1] == valB[W-1]) && (valE[W-1] != valA[W-1]);
      c_SUB:   w_of = (valB[W-1] != valA[W-1]) && (valE[W-1] != valB[W-1]);
      default: w_of = 1'b0;
    endcase
  end

  assign w_cc_we = (icode == c_OPQ) && !alu_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_cc_we) begin
      r_zf <= (valE == '0);
      r_sf <= valE[W-1];
      r_of <= w_of;
    end
  end

  assign zf = r_zf;
  assign sf = r_sf;
  assign of = r_of;

  // Conditions read only the committed flags, never this cycle's ALU result.
  assign w_lt = r_sf ^ r_of;

  always_comb begin
    cnd = 1'b0;
    if ((icode == c_CMOV) || (icode == c_JXX)) begin
      case (ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = w_lt | r_zf;
        4'h2:    cnd = w_lt;
        4'h3:    cnd = r_zf;
        4'h4:    cnd = ~r_zf;
        4'h5:    cnd = ~w_lt;
        4'h6:    cnd = ~w_lt & ~r_zf;
        default: cnd = 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_execute.sv
`default_nettype none
// Bench for y86_execute: spec-level model checked every cycle, plus literal checkpoints.
module tb_y86_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  icode, ifun;
  logic [63:0] valA, valB, valC;
  logic [63:0] valE;
  logic        cnd, zf, sf, of, alu_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        m_zf, m_sf, m_of;
  logic        chk_on = 1'b0;
  logic [63:0] m_vale;

  y86_execute #(.W(64)) dut (
    .clk(clk), .rst(rst), .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .valE(valE), .cnd(cnd), .zf(zf), .sf(sf), .of(of), .alu_err(alu_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
    case (ic)
      4'd2: return a;
      4'd3: return c;
      4'd4, 4'd5: return b + c;
      4'd6: begin
        if (fn == 4'd0) return b + a;
        if (fn == 4'd1) return b - a;
        if (fn == 4'd2) return b & a;
        if (fn == 4'd3) return b ^ a;
        return 64'd0;
      end
      4'd8, 4'd10: return b - 64'd8;
      4'd9, 4'd11: return b + 64'd8;
      default: return 64'd0;
    endcase
  endfunction

  // Overflow as disagreement between a 65-bit signed result and its 64-bit truncation.
  function automatic logic model_of(input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    if (fn == 4'd0)      s = {b[63], b} + {a[63], a};
    else if (fn == 4'd1) s = {b[63], b} - {a[63], a};
    else return 1'b0;
    return s[64] ^ s[63];
  endfunction

  function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic z, input logic s, input logic o);
    logic lt;
    lt = s ^ o;
    if (ic != 4'd2 && ic != 4'd7) return 1'b0;
    case (fn)
      4'd0: return 1'b1;
      4'd1: return lt | z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  assign m_vale = model_vale(icode, ifun, valA, valB, valC);

  always @(posedge clk) begin
    if (rst) begin
      m_zf   <= 1'b1;
      m_sf   <= 1'b0;
      m_of   <= 1'b0;
      chk_on <= 1'b1;
    end else if (icode == 4'd6 && ifun <= 4'd3) begin
      m_zf <= (m_vale == 64'd0);
      m_sf <= m_vale[63];
      m_of <= model_of(ifun, valA, valB);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_valE", valE, m_vale);
      check("model_alu_err", {63'd0, alu_err}, {63'd0, icode == 4'd6 && ifun > 4'd3});
      check("model_cnd", {63'd0, cnd}, {63'd0, model_cnd(icode, ifun, m_zf, m_sf, m_of)});
      check("model_zf", {63'd0, zf}, {63'd0, m_zf});
      check("model_sf", {63'd0, sf}, {63'd0, m_sf});
      check("model_of", {63'd0, of}, {63'd0, m_of});
    end
  end

  task automatic step(input logic r, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    @(posedge clk);
    #1;
    rst = r; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    @(negedge clk);
  endtask

  task automatic flags(input string name, input logic z, input logic s, input logic o);
    check({name, "_zf"}, {63'd0, zf}, {63'd0, z});
    check({name, "_sf"}, {63'd0, sf}, {63'd0, s});
    check({name, "_of"}, {63'd0, of}, {63'd0, o});
  endtask

  initial begin
    rst = 1'b1; icode = 4'd6; ifun = 4'd0; valA = 64'd5; valB = 64'd5; valC = 64'd0;
    @(negedge clk);
    check("reset_valE", valE, 64'd10);
    // rst held: OPq with a nonzero result must not touch CC
    step(1'b1, 4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    check("rsthold_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step(1'b0, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);
    flags("reset", 1'b1, 1'b0, 1'b0);

    step(1'b0, 4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("addov_valE", valE, 64'h8000_0000_0000_0000);
    step(1'b0, 4'd3, 4'd0, 64'd0, 64'd0, 64'd0);
    check("irmov_valE", valE, 64'd0);
    flags("addov", 1'b0, 1'b1, 1'b1);
    step(1'b0, 4'd10, 4'd0, 64'd0, 64'h100, 64'd0);
    check("push_valE", valE, 64'hF8);
    step(1'b0, 4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
    check("jl_cnd", {63'd0, cnd}, 64'd0);
    flags("hold", 1'b0, 1'b1, 1'b1);

    step(1'b0, 4'd6, 4'd1, 64'd42, 64'd42, 64'd0);
    check("sub0_valE", valE, 64'd0);
    step(1'b0, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
    check("je_cnd", {63'd0, cnd}, 64'd1);
    step(1'b0, 4'd7, 4'd4, 64'd0, 64'd0, 64'd0);
    check("jne_cnd", {63'd0, cnd}, 64'd0);
    step(1'b0, 4'd2, 4'd6, 64'h55, 64'd0, 64'd0);
    check("cmovg_cnd", {63'd0, cnd}, 64'd0);
    check("cmov_valE", valE, 64'h55);

    step(1'b0, 4'd9, 4'd0, 64'd0, 64'd0, 64'd0);
    check("ret_valE", valE, 64'h8);
    step(1'b0, 4'd8, 4'd0, 64'd0, 64'd0, 64'd0);
    check("call_valE", valE, 64'hFFFF_FFFF_FFFF_FFF8);
    step(1'b0, 4'd6, 4'd5, 64'd3, 64'd4, 64'd0);
    check("badop_valE", valE, 64'd0);
    check("badop_err", {63'd0, alu_err}, 64'd1);
    step(1'b0, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0);
    flags("badop", 1'b1, 1'b0, 1'b0);

    step(1'b0, 4'd6, 4'd0, 64'd1, 64'd1, 64'd0);
    step(1'b0, 4'd6, 4'd1, 64'd7, 64'd7, 64'd0);
    check("same_valE", valE, 64'd0);
    check("same_cnd", {63'd0, cnd}, 64'd0);
    check("same_zf_old", {63'd0, zf}, 64'd0);
    step(1'b0, 4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
    check("same_zf_new", {63'd0, zf}, 64'd1);

    step(1'b0, 4'd6, 4'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    check("wrap_valE", valE, 64'd0);
    step(1'b0, 4'd7, 4'd0, 64'd0, 64'd0, 64'd0);
    flags("wrap", 1'b1, 1'b0, 1'b0);

    // Sub overflow: MIN - 1 -> positive result with of=1, so l/le true, ge/g false
    step(1'b0, 4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    check("subov_valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    step(1'b0, 4'd7, 4'd5, 64'd0, 64'd0, 64'd0);
    flags("subov", 1'b0, 1'b0, 1'b1);
    check("jge_cnd", {63'd0, cnd}, 64'd0);
    step(1'b0, 4'd7, 4'd1, 64'd0, 64'd0, 64'd0);
    check("jle_cnd", {63'd0, cnd}, 64'd1);
    step(1'b0, 4'd2, 4'd7, 64'd0, 64'd0, 64'd0);
    step(1'b0, 4'd6, 4'd3, 64'hF0F0, 64'hFF00, 64'd0);
    check("xor_valE", valE, 64'h0FF0);
    step(1'b0, 4'd6, 4'd2, 64'hF0F0, 64'hFF00, 64'd0);
    check("and_valE", valE, 64'hF000);
    step(1'b0, 4'd5, 4'd0, 64'd0, 64'h1000, 64'h20);
    check("mrmov_valE", valE, 64'h1020);
    step(1'b0, 4'd15, 4'd0, 64'd9, 64'd9, 64'd9);
    check("nop15_valE", valE, 64'd0);
    step(1'b0, 4'd0, 4'd0, 64'd0, 64'd0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_execute.md
Name: y86_execute

Overview:
- Execute stage of the Y86-64 SEQ processor; sits directly downstream of the register-file/decode block.
- Consumes valA/valB from decode plus icode/ifun/valC from fetch.
- Produces valE (ALU result) for memory/writeback, and cnd, which feeds back into the register file to gate cmovXX writes and is consumed by PC-select for jXX.
- Owns the architectural condition-code register (ZF, SF, OF), the only sequential state in the stage.

Parameters:
- W, 64, datapath width in bits.

Ports:
- clk  input  1  system clock; CC updates on rising edge.
- rst  input  1  synchronous active-high reset.
- icode  input  4  instruction code.
- ifun  input  4  function code (ALU op for OPq, condition for jXX/cmovXX).
- valA  input  W  operand A from register file.
- valB  input  W  operand B from register file.
- valC  input  W  constant from fetch.
- valE  output  W  ALU result, combinational.
- cnd  output  1  condition result, combinational.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.
- alu_err  output  1  high when icode=6 with ifun>3, combinational.

Behaviour:
Clock and reset:
- One clock; reset is synchronous and active-high.
- Reset applies at the rising edge of clk while rst=1: zf=1, sf=0, of=0.
- Reset has priority over any CC update in the same cycle.
- valE, cnd and alu_err are purely combinational and are not reset.

ALU operand/function select by icode (all arithmetic modulo 2^64, carry discarded):
- 2 cmovXX: valE = valA.
- 3 irmovq: valE = valC.
- 4 rmmovq, 5 mrmovq: valE = valB + valC.
- 6 OPq:
  - ifun 0: valB + valA.
  - ifun 1: valB - valA.
  - ifun 2: valB & valA.
  - ifun 3: valB ^ valA.
  - ifun >3: valE = 0 and alu_err = 1.
- 8 call, 10 pushq: valE = valB - 8.
- 9 ret, 11 popq: valE = valB + 8.
- All others (0 halt, 1 nop, 7 jXX, 12-15): valE = 0.

Condition codes:
- CC updates only on a rising edge with icode=6, alu_err=0 and rst=0.
- zf = (valE == 0).
- sf = valE[W-1].
- of, add: valA[W-1]==valB[W-1] and valE[W-1]!=valA[W-1].
- of, sub: valB[W-1]!=valA[W-1] and valE[W-1]!=valB[W-1].
- of, and/xor: 0.
- Every other icode, including OPq with bad ifun, holds CC unchanged.

cnd evaluation:
- Uses the registered CC values, never the flags being computed in the same cycle.
- ifun 0: 1.
- ifun 1 (le): (sf^of)|zf.
- ifun 2 (l): sf^of.
- ifun 3 (e): zf.
- ifun 4 (ne): ~zf.
- ifun 5 (ge): ~(sf^of).
- ifun 6 (g): ~(sf^of)&~zf.
- ifun >6: 0.
- cnd is driven by the table only when icode is 2 or 7; otherwise cnd = 0.

Boundary conditions:
- Back-to-back OPq: the second instruction's cnd (if any) sees the first instruction's flags; the ALU result is independent of CC.
- 64-bit wrap: 0xFFFF_FFFF_FFFF_FFFF + 1 gives valE = 0, zf=1, of=0.
- Most-negative overflow: 0x7FFF_FFFF_FFFF_FFFF + 1 gives sf=1, of=1.
- rst held high: CC stays at reset value regardless of icode; valE still computes.

Test Plan:
- Reset: rst=1 for one edge with icode=6, ifun=0, valA=valB=5 -> after edge zf=1, sf=0, of=0; valE=10 combinationally during the reset cycle.
- Add overflow: icode=6, ifun=0, valA=1, valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0x8000_0000_0000_0000; after edge zf=0, sf=1, of=1.
- Sub to zero, then condition: icode=6, ifun=1, valA=valB=42 -> valE=0, zf=1 after edge. Next cycle icode=7, ifun=3 gives cnd=1; icode=7, ifun=4 gives cnd=0; icode=2, ifun=6 gives cnd=0.
- CC hold: after the add-overflow case, apply icode=3, valC=0 then icode=10, valB=0x100 -> valE=0 then valE=0xF8; flags unchanged (sf=1, of=1); icode=7, ifun=2 gives cnd=0 (sf^of=0).
- Stack arithmetic and bad op: icode=9, valB=0x0 -> valE=0x8. icode=8, valB=0x0 -> valE=0xFFFF_FFFF_FFFF_FFF8. icode=6, ifun=5 -> valE=0, alu_err=1, CC unchanged after edge.
- Same-cycle cnd uses old flags: with zf=0, present icode=6, ifun=1, valA=valB=7 -> valE=0; cnd stays 0 (icode≠2/7); zf becomes 1 only after the edge.
